muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Sequences the shared iterative M-extension units (multiplier, divider) for the EX stage. Latches an M-type request, dispatches it to the correct unit with a one-cycle start pulse and holds the pipeline via stall_o. Selects the correct result half, and resolves divide-by-zero and signed-overflow cases without starting the divider. Handles flush by draining the in-flight unit without writeback.

Parameters:
XLEN, 32, datapath width
OP_W, 3, op code width (RV32M funct3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
req_i  in  1  EX holds a valid M-extension instruction
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a_i  in  XLEN  rs1 value (forwarded SrcA)
operand_b_i  in  XLEN  rs2 value (forwarded SrcB)
flush_i  in  1  kill the EX-stage instruction
stall_o  out  1  to hazard unit: freeze F/D/E
valid_o  out  1  one-cycle pulse: result_o valid for EX writeback
result_o  out  XLEN  selected result
busy_o  out  1  state != IDLE
mul_start_o  out  1  one-cycle start pulse to multiplier
mul_opcode_o  out  2  00 u×u, 01 s×s, 10 s×u
mul_done_i  in  1  multiplier finished
mul_product_i  in  2*XLEN  full product
div_start_o  out  1  one-cycle start pulse to divider
div_signed_o  out  1  signed divide
div_done_i  in  1  divider finished
div_quotient_i  in  XLEN  quotient
div_remainder_i  in  XLEN  remainder
unit_a_o, unit_b_o  out  XLEN  latched operands to both units

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0; result_o=0; latched op/operands 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE, ABORT.
- IDLE:
  - stall_o = req_i & ~flush_i, combinational.
  - On an edge with req_i=1 and flush_i=0: latch op and operands.
  - Special case → DONE, with no unit start:
    - b==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
    - DIV with a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - Otherwise op[2]=0 → MUL_WAIT; op[2]=1 → DIV_WAIT.
- MUL_WAIT / DIV_WAIT:
  - start pulse high only in the first cycle of the state.
  - mul_opcode_o: 01 for MUL/MULH, 10 for MULHSU, 00 for MULHU. div_signed_o = ~op[0].
  - stall_o=1.
  - On the matching done_i: register result, → DONE.
    - MUL → product[31:0]; MULH* → product[63:32].
    - DIV* → quotient; REM* → remainder.
  - done_i from the non-selected unit is ignored.
- DONE: valid_o=1, stall_o=0 (EX advances this cycle). req_i is ignored. → IDLE.
  - Minimum latency: special case 1 stall cycle; unit op = unit latency + 1 stall cycles.
- flush_i:
  - In MUL_WAIT/DIV_WAIT → ABORT. Unit keeps running; no valid_o.
  - In IDLE: request not accepted.
  - In DONE: valid_o is suppressed that cycle.
- ABORT:
  - stall_o = req_i (a new request must wait until the unit is idle).
  - On the awaited done_i → IDLE; result_o unchanged.
- result_o holds its last value outside DONE.
- A done_i arriving in the same cycle as flush_i in a WAIT state: flush wins → IDLE directly, no valid_o.
- Reset mid-operation returns to IDLE immediately. The units share rst.

Optional Feature:
MULDIV_FUSE_EN
- Defined: keep tag {class, mul_opcode/div_signed, a, b, tag_valid} plus the last 64-bit product or quotient/remainder.
- A new request whose operands and signedness match the tag → DONE directly, with no start pulse (1 stall cycle). MUL matches any mul tag, since the low half is sign-independent.
- Tag is written on every DONE that used a unit and cleared only by reset.
- Undefined: no tag logic; every non-special request dispatches to its unit.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → one mul_start_o, mul_opcode_o=01, valid_o pulse with result_o=0xFFFFFFEB; stall_o high from request until DONE.
- MULH a=b=0x80000000 → result_o=0x40000000; MULHU with the same operands → 0x40000000; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → div_start_o never asserted, result_o=0x80000000 after 1 stall cycle; REMU a=5, b=0 → 5; DIVU b=0 → 0xFFFFFFFF.
- DIV a=100, b=7 with flush_i in the 3rd DIV_WAIT cycle → ABORT, no valid_o; a new req_i stays stalled until div_done_i; then REM a=100, b=7 → 2.
- Async reset asserted mid-MUL_WAIT → all outputs 0 immediately; a later mul_done_i is ignored.
- With MULDIV_FUSE_EN: MULHU a=3, b=5, then MUL a=3, b=5 → second op has no mul_start_o, result_o=15 after 1 stall cycle. Without the macro → a second start pulse is issued.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_sequencer_if                                              |
// | Sequencer <-> shared multiplier/divider bus.                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic                mul_start_o;
    logic [1:0]          mul_opcode_o;
    logic                mul_done_i;
    logic [2*XLEN-1:0]   mul_product_i;
    logic                div_start_o;
    logic                div_signed_o;
    logic                div_done_i;
    logic [XLEN-1:0]     div_quotient_i;
    logic [XLEN-1:0]     div_remainder_i;
    logic [XLEN-1:0]     unit_a_o;
    logic [XLEN-1:0]     unit_b_o;

    modport master (
        output mul_start_o, mul_opcode_o, div_start_o, div_signed_o, unit_a_o, unit_b_o,
        input  mul_done_i, mul_product_i, div_done_i, div_quotient_i, div_remainder_i
    );

    modport slave (
        input  mul_start_o, mul_opcode_o, div_start_o, div_signed_o, unit_a_o, unit_b_o,
        output mul_done_i, mul_product_i, div_done_i, div_quotient_i, div_remainder_i
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_sequencer                                                 |
// | Dispatches RV32M ops to the shared mul/div units, stalls EX,     |
// | resolves div-by-zero/overflow locally. Option: MULDIV_FUSE_EN.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int OP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [XLEN-1:0]    operand_a_i,
    input  logic [XLEN-1:0]    operand_b_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               valid_o,
    output logic [XLEN-1:0]    result_o,
    output logic               busy_o,
    muldiv_sequencer_if.master unit
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_WAIT = 3'd1,
        DIV_WAIT = 3'd2,
        DONE     = 3'd3,
        ABORT    = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [1:0] mul_opc_f(input logic [1:0] op_lo);
        case (op_lo)
            2'b10:   mul_opc_f = 2'b10;
            2'b11:   mul_opc_f = 2'b00;
            default: mul_opc_f = 2'b01;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [1:0]        mul_opc_q, mul_opc_d;
    logic              div_signed_q, div_signed_d;
    logic              first_q, first_d;

    logic              w_accept, w_b_zero, w_ovf, w_special, w_unit_done;
    logic [XLEN-1:0]   w_special_res, w_mul_res, w_div_res;

    assign w_accept      = req_i & ~flush_i;
    assign w_b_zero      = (operand_b_i == '0);
    assign w_ovf         = ~op_i[0] & (operand_a_i == c_int_min) & (operand_b_i == '1);
    assign w_special     = op_i[2] & (w_b_zero | w_ovf);
    // Zero divisor takes precedence; the overflow case only applies to signed ops.
    assign w_special_res = w_b_zero ? (op_i[1] ? operand_a_i : '1)
                                    : (op_i[1] ? '0 : c_int_min);
    assign w_mul_res     = (op_q[1:0] == 2'b00) ? unit.mul_product_i[XLEN-1:0]
                                                : unit.mul_product_i[2*XLEN-1:XLEN];
    assign w_div_res     = op_q[1] ? unit.div_remainder_i : unit.div_quotient_i;
    assign w_unit_done   = op_q[2] ? unit.div_done_i : unit.mul_done_i;

`ifdef MULDIV_FUSE_EN
    logic              tag_valid_q, tag_valid_d, tag_cls_q, tag_cls_d;
    logic [1:0]        tag_sgn_q, tag_sgn_d;
    logic [XLEN-1:0]   tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic [2*XLEN-1:0] tag_data_q, tag_data_d;
    logic              w_sgn_match, w_fuse_hit;
    logic [XLEN-1:0]   w_fuse_res;

    // Low product half does not depend on signedness, so MUL hits any mul tag.
    assign w_sgn_match = op_i[2] ? (tag_sgn_q == {1'b0, ~op_i[0]})
                                 : ((op_i[1:0] == 2'b00) | (tag_sgn_q == mul_opc_f(op_i[1:0])));
    assign w_fuse_hit  = tag_valid_q & (tag_cls_q == op_i[2]) & w_sgn_match
                       & (tag_a_q == operand_a_i) & (tag_b_q == operand_b_i);
    assign w_fuse_res  = op_i[2] ? (op_i[1] ? tag_data_q[2*XLEN-1:XLEN] : tag_data_q[XLEN-1:0])
                                 : ((op_i[1:0] == 2'b00) ? tag_data_q[XLEN-1:0]
                                                         : tag_data_q[2*XLEN-1:XLEN]);
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        mul_opc_d    = mul_opc_q;
        div_signed_d = div_signed_q;
        first_d      = 1'b0;
        stall_o      = 1'b0;
        valid_o      = 1'b0;
`ifdef MULDIV_FUSE_EN
        tag_valid_d  = tag_valid_q;
        tag_cls_d    = tag_cls_q;
        tag_sgn_d    = tag_sgn_q;
        tag_a_d      = tag_a_q;
        tag_b_d      = tag_b_q;
        tag_data_d   = tag_data_q;
`endif
        unique case (state_q)
            IDLE: begin
                stall_o = w_accept;
                if (w_accept) begin
                    op_d         = op_i;
                    a_d          = operand_a_i;
                    b_d          = operand_b_i;
                    mul_opc_d    = mul_opc_f(op_i[1:0]);
                    div_signed_d = ~op_i[0];
                    if (w_special) begin
                        result_d = w_special_res;
                        state_d  = DONE;
`ifdef MULDIV_FUSE_EN
                    end else if (w_fuse_hit) begin
                        result_d = w_fuse_res;
                        state_d  = DONE;
`endif
                    end else begin
                        first_d  = 1'b1;
                        state_d  = op_i[2] ? DIV_WAIT : MUL_WAIT;
                    end
                end
            end
            MUL_WAIT, DIV_WAIT: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    // A done coinciding with the flush leaves nothing to drain.
                    state_d = w_unit_done ? IDLE : ABORT;
                end else if (w_unit_done) begin
                    result_d = op_q[2] ? w_div_res : w_mul_res;
                    state_d  = DONE;
`ifdef MULDIV_FUSE_EN
                    tag_valid_d = 1'b1;
                    tag_cls_d   = op_q[2];
                    tag_sgn_d   = op_q[2] ? {1'b0, div_signed_q} : mul_opc_q;
                    tag_a_d     = a_q;
                    tag_b_d     = b_q;
                    tag_data_d  = op_q[2] ? {unit.div_remainder_i, unit.div_quotient_i}
                                          : unit.mul_product_i;
`endif
                end
            end
            DONE: begin
                valid_o = ~flush_i;
                state_d = IDLE;
            end
            ABORT: begin
                stall_o = req_i;
                if (w_unit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            mul_opc_q    <= '0;
            div_signed_q <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            mul_opc_q    <= mul_opc_d;
            div_signed_q <= div_signed_d;
            first_q      <= first_d;
        end
    end

`ifdef MULDIV_FUSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_q <= 1'b0;
            tag_cls_q   <= 1'b0;
            tag_sgn_q   <= '0;
            tag_a_q     <= '0;
            tag_b_q     <= '0;
            tag_data_q  <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_cls_q   <= tag_cls_d;
            tag_sgn_q   <= tag_sgn_d;
            tag_a_q     <= tag_a_d;
            tag_b_q     <= tag_b_d;
            tag_data_q  <= tag_data_d;
        end
    end
`endif

    assign busy_o            = (state_q != IDLE);
    assign result_o          = result_q;
    assign unit.mul_start_o  = (state_q == MUL_WAIT) & first_q;
    assign unit.div_start_o  = (state_q == DIV_WAIT) & first_q;
    assign unit.mul_opcode_o = mul_opc_q;
    assign unit.div_signed_o = div_signed_q;
    assign unit.unit_a_o     = a_q;
    assign unit.unit_b_o     = b_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// Scoreboard bench for muldiv_sequencer with behavioural mul/div units.
module tb_muldiv_sequencer;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        rst, req_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] operand_a_i, operand_b_i;
    logic        stall_o, valid_o, busy_o;
    logic [31:0] result_o;
    logic        mul_done_m, div_done_m, inj_mul_done;

    muldiv_sequencer_if #(.XLEN(32)) u_if ();

    muldiv_sequencer #(.XLEN(32), .OP_W(3)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .flush_i(flush_i),
        .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o), .busy_o(busy_o),
        .unit(u_if)
    );

    always #5 clk = ~clk;

    assign u_if.mul_done_i = mul_done_m | inj_mul_done;
    assign u_if.div_done_i = div_done_m;

    function automatic logic [63:0] ext(input logic [31:0] x, input logic s);
        ext = {{32{s & x[31]}}, x};
    endfunction

    // Behavioural units sharing rst with the sequencer.
    int          mul_cnt, div_cnt;
    logic [63:0] mul_calc;
    logic [31:0] q_calc, r_calc;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt <= 0; mul_done_m <= 1'b0; mul_calc <= '0; u_if.mul_product_i <= '0;
        end else begin
            mul_done_m <= 1'b0;
            if (u_if.mul_start_o) begin
                mul_cnt  <= MUL_LAT;
                mul_calc <= ext(u_if.unit_a_o, u_if.mul_opcode_o != 2'b00)
                          * ext(u_if.unit_b_o, u_if.mul_opcode_o == 2'b01);
            end else if (mul_cnt == 1) begin
                mul_done_m <= 1'b1; u_if.mul_product_i <= mul_calc; mul_cnt <= 0;
            end else if (mul_cnt > 1) mul_cnt <= mul_cnt - 1;
        end
    end
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= 0; div_done_m <= 1'b0; q_calc <= '0; r_calc <= '0;
            u_if.div_quotient_i <= '0; u_if.div_remainder_i <= '0;
        end else begin
            div_done_m <= 1'b0;
            if (u_if.div_start_o) begin
                div_cnt <= DIV_LAT;
                if (u_if.div_signed_o) begin
                    q_calc <= 32'($signed(u_if.unit_a_o) / $signed(u_if.unit_b_o));
                    r_calc <= 32'($signed(u_if.unit_a_o) % $signed(u_if.unit_b_o));
                end else begin
                    q_calc <= u_if.unit_a_o / u_if.unit_b_o;
                    r_calc <= u_if.unit_a_o % u_if.unit_b_o;
                end
            end else if (div_cnt == 1) begin
                div_done_m <= 1'b1; div_cnt <= 0;
                u_if.div_quotient_i <= q_calc; u_if.div_remainder_i <= r_calc;
            end else if (div_cnt > 1) div_cnt <= div_cnt - 1;
        end
    end

    typedef struct { string name; logic [31:0] val; } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int   n_vec = 0, n_err = 0;
    int   n_mul_start = 0, n_div_start = 0;
    logic [1:0] last_mul_opc = '0;
    logic       last_div_sgn = 1'b0;

    // Monitor: counts start pulses and checks every valid_o against the scoreboard.
    always @(negedge clk) begin
        if (u_if.mul_start_o) begin n_mul_start++; last_mul_opc = u_if.mul_opcode_o; end
        if (u_if.div_start_o) begin n_div_start++; last_div_sgn = u_if.div_signed_o; end
        if (valid_o) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: result_o=%h, required no valid_o", result_o);
            end else begin
                e = exp_q.pop_front();
                if (result_o !== e.val) begin
                    n_err++;
                    $display("FAIL %s: result_o=%h required=%h", e.name, result_o, e.val);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic wait_valid(output int cycles, output int stalls);
        bit got = 1'b0;
        cycles = 0; stalls = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (valid_o) got = 1'b1;
            else begin
                cycles++;
                if (stall_o) stalls++;
                @(negedge clk);
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL timeout: valid_o=0 after 100 cycles, required a valid_o pulse");
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input string nm,
                         output int cycles, output int stalls);
        exp_q.push_back('{nm, expv});
        op_i = op; operand_a_i = a; operand_b_i = b; req_i = 1'b1;
        wait_valid(cycles, stalls);
        req_i = 1'b0;
        @(negedge clk);
    endtask

    int cyc, st, s0, s1;

    initial begin
        rst = 1'b0; req_i = 1'b0; flush_i = 1'b0; op_i = '0;
        operand_a_i = '0; operand_b_i = '0; inj_mul_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_unit_bus", {u_if.mul_start_o, u_if.div_start_o, u_if.mul_opcode_o,
                             u_if.div_signed_o, u_if.unit_a_o, u_if.unit_b_o}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Multiplier paths
        s0 = n_mul_start;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul", cyc, st);
        chk("mul_start_count", n_mul_start - s0, 1);
        chk("mul_opcode_mul", last_mul_opc, 2'b01);
        chk("mul_stall_until_done", st, cyc);
        chk("mul_min_latency", cyc >= MUL_LAT + 1, 1);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh", cyc, st);
        chk("mul_opcode_mulh", last_mul_opc, 2'b01);
        issue(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu", cyc, st);
        chk("mul_opcode_mulhu", last_mul_opc, 2'b00);
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu", cyc, st);
        chk("mul_opcode_mulhsu", last_mul_opc, 2'b10);

        // Divider special cases: resolved without a start pulse
        s0 = n_div_start;
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", cyc, st);
        chk("div_ovf_stalls", st, 1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf", cyc, st);
        issue(3'b111, 32'd5, 32'd0, 32'd5, "remu_by0", cyc, st);
        issue(3'b101, 32'd1234, 32'd0, 32'hFFFF_FFFF, "divu_by0", cyc, st);
        issue(3'b100, 32'd9, 32'd0, 32'hFFFF_FFFF, "div_by0", cyc, st);
        issue(3'b110, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, "rem_by0", cyc, st);
        chk("special_no_div_start", n_div_start - s0, 0);

        // Normal divides, signed vs unsigned
        issue(3'b100, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, "div_signed", cyc, st);
        chk("div_signed_flag", last_div_sgn, 1);
        issue(3'b101, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, "divu", cyc, st);
        chk("divu_signed_flag", last_div_sgn, 0);

        // Flush in IDLE: request not accepted
        op_i = 3'b000; req_i = 1'b1; flush_i = 1'b1;
        #1 chk("flush_idle_stall", stall_o, 0);
        @(negedge clk);
        chk("flush_idle_busy", busy_o, 0);
        req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);

        // Flush in DONE: valid_o suppressed
        op_i = 3'b101; operand_a_i = 32'd3; operand_b_i = 32'd0; req_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b1; req_i = 1'b0;
        #1 chk("flush_done_valid", valid_o, 0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_done_idle", busy_o, 0);

        // Flush in 3rd DIV_WAIT cycle, then a held REM waits for the drain
        s0 = n_div_start;
        op_i = 3'b100; operand_a_i = 32'd100; operand_b_i = 32'd7; req_i = 1'b1;
        repeat (3) @(negedge clk);
        flush_i = 1'b1; req_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        chk("abort_busy", busy_o, 1);
        issue(3'b110, 32'd100, 32'd7, 32'd2, "rem_after_abort", cyc, st);
        chk("abort_stall_held", st, cyc);
        chk("abort_waited_for_unit", cyc >= 4, 1);
        chk("abort_div_starts", n_div_start - s0, 2);

        // Async reset mid-MUL_WAIT
        op_i = 3'b000; operand_a_i = 32'd9; operand_b_i = 32'd9; req_i = 1'b1;
        repeat (2) @(negedge clk);
        req_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_outputs", {stall_o, valid_o, result_o}, 0);
        chk("arst_unit_bus", {u_if.mul_start_o, u_if.mul_opcode_o, u_if.unit_a_o, u_if.unit_b_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        inj_mul_done = 1'b1;
        @(negedge clk);
        inj_mul_done = 1'b0;
        #1 chk("stray_done_ignored", {busy_o, valid_o, result_o}, 0);
        @(negedge clk);

        // Repeat operands: reuse of the tagged product when fusion is built in
        issue(3'b011, 32'd3, 32'd5, 32'd0, "mulhu_3x5", cyc, st);
        s1 = n_mul_start;
        issue(3'b000, 32'd3, 32'd5, 32'd15, "mul_3x5", cyc, st);
`ifdef MULDIV_FUSE_EN
        chk("fuse_no_start", n_mul_start - s1, 0);
        chk("fuse_stalls", st, 1);
`else
        chk("nofuse_second_start", n_mul_start - s1, 1);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
